// File: rtl/seq_pkg.sv
// seq_pkg -- shared definitions for the serial pattern generator and the
// 1101 sequence detectors.
//   state_t  : FSM state encoding (IDLE, SEND, GAP)
//   PAT_1101 : default 4-bit pattern 1101
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int          PAT_1101_W = 4;
  localparam logic [3:0]  PAT_1101   = 4'b1101;

endpackage

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen -- serial burst pattern generator.
// Sends repeat_n frames of a PAT_W-bit pattern (MSB first), with gap idle
// cycles between consecutive frames. All outputs are registered.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                begin a burst (sampled only while ready=1)
//   use_def              1: send DEF_PAT, 0: send pattern
//   pattern [PAT_W]      programmable pattern
//   repeat_n [CNT_W]     number of frames (0 = request ignored)
//   gap [GAP_W]          idle cycles between frames
//   abort                synchronous burst cancel (wins over start)
//   ready                idle, start will be accepted
//   out, out_valid       serial bit and its qualifier
//   frame_start/_end     first / last bit of a frame is on out
//   done                 one-cycle pulse after normal burst completion
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 4,
  parameter int               GAP_W   = 2,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(PAT_1101)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_def,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             done
);

  localparam int              BC_W     = $clog2(PAT_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(PAT_W - 1);

  state_t           state;
  logic [PAT_W-1:0] pat_q;    // captured pattern, reloaded for every frame
  logic [PAT_W-1:0] sh;       // remaining bits of the current frame, MSB next
  logic [BC_W-1:0]  bit_cnt;  // bits still to send after the one on out
  logic [CNT_W-1:0] frm_cnt;  // frames still to send after the current one
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;  // idle cycles left after the current one

  logic [PAT_W-1:0] sel_pat;
  logic             accept;

  assign sel_pat = use_def ? DEF_PAT : pattern;
  assign accept  = start && (repeat_n != '0) && !abort;

  // Outputs are computed one edge ahead: the registers always describe the
  // cycle that follows the edge, so state SEND means "a bit is on out now".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ready       <= 1'b1;
      out         <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      done        <= 1'b0;
      pat_q       <= '0;
      sh          <= '0;
      bit_cnt     <= '0;
      frm_cnt     <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
    end else begin
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          ready     <= 1'b1;
          out       <= 1'b0;
          out_valid <= 1'b0;
          if (accept) begin
            state       <= SEND;
            ready       <= 1'b0;
            pat_q       <= sel_pat;
            sh          <= sel_pat << 1;
            out         <= sel_pat[PAT_W-1];
            out_valid   <= 1'b1;
            frame_start <= 1'b1;
            bit_cnt     <= LAST_BIT;
            frm_cnt     <= repeat_n - CNT_W'(1);
            gap_q       <= gap;
          end
        end

        SEND: begin
          if (abort) begin
            state     <= IDLE;
            ready     <= 1'b1;
            out       <= 1'b0;
            out_valid <= 1'b0;
          end else if (bit_cnt != '0) begin
            out       <= sh[PAT_W-1];
            sh        <= sh << 1;
            bit_cnt   <= bit_cnt - BC_W'(1);
            frame_end <= (bit_cnt == BC_W'(1));
          end else if (frm_cnt == '0) begin
            // LSB of the last frame was on out: burst complete
            state     <= IDLE;
            ready     <= 1'b1;
            out       <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b1;
          end else begin
            frm_cnt <= frm_cnt - CNT_W'(1);
            if (gap_q == '0) begin
              // back-to-back: next MSB immediately follows this LSB
              sh          <= pat_q << 1;
              out         <= pat_q[PAT_W-1];
              out_valid   <= 1'b1;
              frame_start <= 1'b1;
              bit_cnt     <= LAST_BIT;
            end else begin
              state     <= GAP;
              gap_cnt   <= gap_q - GAP_W'(1);
              out       <= 1'b0;
              out_valid <= 1'b0;
            end
          end
        end

        GAP: begin
          if (abort) begin
            state     <= IDLE;
            ready     <= 1'b1;
            out       <= 1'b0;
            out_valid <= 1'b0;
          end else if (gap_cnt == '0) begin
            state       <= SEND;
            sh          <= pat_q << 1;
            out         <= pat_q[PAT_W-1];
            out_valid   <= 1'b1;
            frame_start <= 1'b1;
            bit_cnt     <= LAST_BIT;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        default: begin
          state     <= IDLE;
          ready     <= 1'b1;
          out       <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen -- self-checking bench for seq_pattern_gen.
// The expected per-cycle output stream of a burst is built as a list of
// cycles from the burst parameters; a behavioural 1101 detector observes
// out for the loopback case.
module tb_seq_pattern_gen;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;
  localparam int GAP_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             use_def;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             ready;
  logic             out;
  logic             out_valid;
  logic             frame_start;
  logic             frame_end;
  logic             done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic o;
    logic v;
    logic fs;
    logic fe;
    logic dn;
    logic rd;
  } exp_t;

  exp_t       q[$];
  logic [3:0] def_pat;
  int         det_hits;
  int         det_len;
  logic [2:0] det_hist;

  always #5 clk = ~clk;

  seq_pattern_gen #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W),
    .GAP_W(GAP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .use_def    (use_def),
    .pattern    (pattern),
    .repeat_n   (repeat_n),
    .gap        (gap),
    .abort      (abort),
    .ready      (ready),
    .out        (out),
    .out_valid  (out_valid),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_cycle(input string pfx, input exp_t e);
    chk({pfx, "_out"},   32'(out),         32'(e.o));
    chk({pfx, "_vld"},   32'(out_valid),   32'(e.v));
    chk({pfx, "_fs"},    32'(frame_start), 32'(e.fs));
    chk({pfx, "_fe"},    32'(frame_end),   32'(e.fe));
    chk({pfx, "_done"},  32'(done),        32'(e.dn));
    chk({pfx, "_ready"}, 32'(ready),       32'(e.rd));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected cycles 1.. after acceptance: frames of PAT_W bits separated by
  // g idle cycles, then the done cycle, then one plain idle cycle.
  task automatic build(input logic [PAT_W-1:0] pat, input int n, input int g);
    exp_t e;
    q.delete();
    for (int f = 0; f < n; f++) begin
      for (int b = 0; b < PAT_W; b++) begin
        e = '{o: pat[PAT_W-1-b], v: 1'b1, fs: (b == 0), fe: (b == PAT_W-1), dn: 1'b0, rd: 1'b0};
        q.push_back(e);
      end
      if (f < n-1)
        for (int k = 0; k < g; k++) q.push_back(6'b000000);
    end
    q.push_back('{o: 1'b0, v: 1'b0, fs: 1'b0, fe: 1'b0, dn: 1'b1, rd: 1'b1});
    q.push_back('{o: 1'b0, v: 1'b0, fs: 1'b0, fe: 1'b0, dn: 1'b0, rd: 1'b1});
  endtask

  function automatic int active_len(input int n, input int g);
    return n * PAT_W + (n - 1) * g;
  endfunction

  // Start a burst now (cycle 0) and check every cycle until it is idle again.
  // abort_at>0 raises abort during that cycle number.
  task automatic run_burst(input string nm, input logic [PAT_W-1:0] pat, input logic ud,
                           input int n, input int g, input int abort_at, input bit loop_det);
    logic det;
    use_def  = ud;
    pattern  = pat;
    repeat_n = CNT_W'(n);
    gap      = GAP_W'(g);
    abort    = 1'b0;
    start    = 1'b1;
    build(ud ? def_pat : pat, n, g);
    if (abort_at > 0) begin
      while (q.size() > abort_at) void'(q.pop_back());
      q.push_back(6'b000001);
      q.push_back(6'b000001);
    end
    for (int i = 0; i < q.size(); i++) begin
      tick();
      chk_cycle($sformatf("%s_c%0d", nm, i + 1), q[i]);
      if (loop_det) begin
        det = (det_len >= 3) && (det_hist == 3'b110) && out;
        if (det) begin
          det_hits++;
          det_len = 0;
        end else begin
          det_hist = {det_hist[1:0], out};
          det_len++;
        end
        chk($sformatf("%s_det_c%0d", nm, i + 1), 32'(det), 32'(frame_end));
      end
      abort = (i == abort_at - 1);
      if (!q[i].rd && (i + 1 < q.size()) && !loop_det) begin
        // while busy, start and the burst inputs must be ignored
        start    = 1'($urandom_range(0, 1));
        pattern  = PAT_W'($urandom);
        repeat_n = CNT_W'($urandom);
        gap      = GAP_W'($urandom);
        use_def  = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int n;
    int g;
    int ab;
    def_pat  = 4'b1101;
    rst      = 1'b1;
    start    = 1'b0;
    use_def  = 1'b0;
    pattern  = '0;
    repeat_n = '0;
    gap      = '0;
    abort    = 1'b0;
    det_hits = 0;
    det_len  = 0;
    det_hist = '0;

    #2;
    chk_cycle("rst0", 6'b000001);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_cycle("idle0", 6'b000001);

    // default pattern, single frame
    run_burst("def1", 4'b0000, 1'b1, 1, 0, 0, 1'b0);
    // programmed 1101, two frames back-to-back
    run_burst("b2b", 4'b1101, 1'b0, 2, 0, 0, 1'b0);
    // three frames with a two-cycle gap
    run_burst("gap2", 4'b1011, 1'b0, 3, 2, 0, 1'b0);
    // abort in cycle 2 of a two-frame burst
    run_burst("abrt", 4'b0110, 1'b0, 2, 0, 2, 1'b0);
    // abort while in a gap
    run_burst("abgap", 4'b1001, 1'b0, 3, 3, 6, 1'b0);

    // start with repeat_n=0 is ignored
    use_def  = 1'b1;
    repeat_n = '0;
    start    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cycle($sformatf("rn0_c%0d", i + 1), 6'b000001);
    end
    // abort together with start in idle: abort wins
    repeat_n = CNT_W'(2);
    abort    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cycle($sformatf("abst_c%0d", i + 1), 6'b000001);
    end
    start = 1'b0;
    abort = 1'b0;

    // reset in cycle 6 of a three-frame burst
    use_def  = 1'b1;
    repeat_n = CNT_W'(3);
    gap      = GAP_W'(1);
    start    = 1'b1;
    build(def_pat, 3, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      start = 1'b0;
      chk_cycle($sformatf("prerst_c%0d", i + 1), q[i]);
    end
    rst = 1'b1;
    #1;
    chk_cycle("rstmid", 6'b000001);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_cycle("postrst", 6'b000001);
    run_burst("fresh", 4'b0000, 1'b1, 1, 0, 0, 1'b0);

    // loopback into a 1101 detector
    det_hits = 0;
    det_len  = 0;
    det_hist = '0;
    run_burst("loop", 4'b0000, 1'b1, 3, 1, 0, 1'b1);
    chk("loop_hits", 32'(det_hits), 32'd3);

    // randomized bursts
    for (int r = 0; r < 30; r++) begin
      n  = $urandom_range(1, 15);
      g  = $urandom_range(0, 3);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, active_len(n, g)) : 0;
      run_burst($sformatf("rnd%0d", r), PAT_W'($urandom), 1'($urandom_range(0, 1)), n, g, ab, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
